// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Latches the granted byte, launches it with a one-cycle valid, then follows tx_busy.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in_i,
  input  logic [NUM_REQ-1:0]              par_en_in_i,
  input  logic                            tx_busy_i,
  output logic [DATA_WIDTH-1:0]           tx_data_o,
  output logic                            tx_par_en_o,
  output logic                            tx_data_valid_o,
  output logic [NUM_REQ-1:0]              ack_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            timeout_err_o,
  output logic [$clog2(NUM_REQ)-1:0]      active_id_o
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned TimerW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

  state_e                  state_q, state_d;
  logic [IdW-1:0]          ptr_q, ptr_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_par_en_q, tx_par_en_d;
  logic                    valid_q, valid_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic [IdW-1:0]          active_id_q, active_id_d;

  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
  logic                    sel_valid;
  logic [IdW-1:0]          sel_id;
  logic [IdW-1:0]          idx;
  logic [IdW-1:0]          next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
    assign data_arr[g] = data_in_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First set request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IdW'((32'(ptr_q) + i) % NUM_REQ);
      if (!sel_valid && req_i[idx]) begin
        sel_valid = 1'b1;
        sel_id    = idx;
      end
    end
  end

  assign next_ptr = (active_id_q == IdW'(NUM_REQ - 1)) ? '0 : active_id_q + IdW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    tx_data_d   = tx_data_q;
    tx_par_en_d = tx_par_en_q;
    active_id_d = active_id_q;
    valid_d     = 1'b0;
    ack_d       = '0;
    done_d      = '0;
    timeout_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          tx_data_d   = data_arr[sel_id];
          tx_par_en_d = par_en_in_i[sel_id];
          active_id_d = sel_id;
          valid_d     = 1'b1;
          state_d     = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy_i) begin
          ack_d[active_id_q] = 1'b1;
          state_d            = StWaitDone;
        end else if (timer_q == TimerW'(BUSY_TIMEOUT - 2)) begin
          // This cycle's increment would reach BUSY_TIMEOUT-1: give up on the frame.
          timeout_d = 1'b1;
          ptr_d     = next_ptr;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy_i) begin
          done_d[active_id_q] = 1'b1;
          ptr_d               = next_ptr;
          state_d             = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      timer_q     <= '0;
      tx_data_q   <= '0;
      tx_par_en_q <= 1'b0;
      valid_q     <= 1'b0;
      ack_q       <= '0;
      done_q      <= '0;
      timeout_q   <= 1'b0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      tx_par_en_q <= tx_par_en_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      active_id_q <= active_id_d;
    end
  end

  assign tx_data_o       = tx_data_q;
  assign tx_par_en_o     = tx_par_en_q;
  assign tx_data_valid_o = valid_q;
  assign ack_o           = ack_q;
  assign done_o          = done_q;
  assign timeout_err_o   = timeout_q;
  assign active_id_o     = active_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, latency, timeout, mid-frame reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  par_en;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_par_en;
  logic        tx_valid;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        timeout_err;
  logic [1:0]  active_id;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .DATA_WIDTH   (8),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_i           (req),
    .data_in_i       (data_in),
    .par_en_in_i     (par_en),
    .tx_busy_i       (tx_busy),
    .tx_data_o       (tx_data),
    .tx_par_en_o     (tx_par_en),
    .tx_data_valid_o (tx_valid),
    .ack_o           (ack),
    .done_o          (done),
    .timeout_err_o   (timeout_err),
    .active_id_o     (active_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the launch pulse, then checks the latched frame.
  task automatic expect_launch(input int id, input logic [7:0] data);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!tx_valid && n < 10);
    chk("launch_seen", 32'(tx_valid), 32'h1);
    chk("launch_id", 32'(active_id), 32'(id));
    chk("launch_data", 32'(tx_data), 32'(data));
  endtask

  // Busy rises in the launch cycle, stays high 10 cycles, then the frame ends.
  task automatic complete(input int id);
    tx_busy = 1'b1;
    tick();
    tick();
    chk("ack", 32'(ack), 32'h1 << id);
    repeat (8) tick();
    chk("no_early_done", 32'(done), 32'h0);
    tx_busy = 1'b0;
    tick();
    chk("done", 32'(done), 32'h1 << id);
  endtask

  initial begin
    rst_ni  = 1'b0;
    req     = 4'b0000;
    data_in = 32'h0;
    par_en  = 4'b0000;
    tx_busy = 1'b0;
    tick();
    tick();
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_par_en", 32'(tx_par_en), 32'h0);
    chk("rst_valid", 32'(tx_valid), 32'h0);
    chk("rst_pulses", {22'h0, timeout_err, ack, done, 1'b0}, 32'h0);
    chk("rst_active_id", 32'(active_id), 32'h0);
    rst_ni = 1'b1;

    // Single frame from requester 1, busy two cycles after launch for 20 cycles.
    req          = 4'b0010;
    data_in[15:8] = 8'hA5;
    par_en       = 4'b0010;
    tick();
    chk("t1_valid", 32'(tx_valid), 32'h1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_par_en", 32'(tx_par_en), 32'h1);
    chk("t1_id", 32'(active_id), 32'h1);
    tick();
    chk("t1_valid_pulse", 32'(tx_valid), 32'h0);
    chk("t1_no_ack_yet", 32'(ack), 32'h0);
    tick();
    tx_busy = 1'b1;
    tick();
    chk("t1_ack", 32'(ack), 32'h2);
    req = 4'b0000;
    tick();
    chk("t1_ack_pulse", 32'(ack), 32'h0);
    repeat (18) tick();
    chk("t1_no_done", 32'(done), 32'h0);
    tx_busy = 1'b0;
    tick();
    chk("t1_done", 32'(done), 32'h2);
    tick();
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_hold_data", 32'(tx_data), 32'hA5);
    chk("t1_hold_id", 32'(active_id), 32'h1);

    // Round robin with all requesters pending from a fresh pointer.
    rst_ni = 1'b0;
    tick();
    rst_ni  = 1'b1;
    data_in = 32'h03020100;
    par_en  = 4'b0000;
    req     = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      expect_launch(f % 4, 8'(f % 4));
      chk("rr_par_en", 32'(tx_par_en), 32'h0);
      complete(f % 4);
    end

    // Requester 2 served, then 3 must precede 0.
    req = 4'b0100;
    expect_launch(2, 8'h02);
    complete(2);
    req = 4'b1001;
    expect_launch(3, 8'h03);
    complete(3);

    // Transmitter never goes busy: timeout, then pointer moves past 0.
    req = 4'b0001;
    expect_launch(0, 8'h00);
    repeat (15) tick();
    chk("to_early", 32'(timeout_err), 32'h0);
    tick();
    chk("to_pulse", 32'(timeout_err), 32'h1);
    chk("to_no_ack", 32'(ack), 32'h0);
    chk("to_no_done", 32'(done), 32'h0);
    req = 4'b0011;
    expect_launch(1, 8'h01);
    chk("to_pulse_end", 32'(timeout_err), 32'h0);
    req = 4'b0000;
    complete(1);

    // Reset during WAIT_DONE of requester 2.
    data_in[7:0] = 8'h5A;
    req = 4'b0100;
    expect_launch(2, 8'h02);
    req     = 4'b0000;
    tx_busy = 1'b1;
    tick();
    tick();
    chk("mr_ack", 32'(ack), 32'h4);
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mr_tx_data", 32'(tx_data), 32'h0);
    chk("mr_active_id", 32'(active_id), 32'h0);
    chk("mr_pulses", {23'h0, tx_valid, timeout_err, ack, done[2:0]}, 32'h0);
    tx_busy = 1'b0;
    tick();
    chk("mr_no_done", 32'(done), 32'h0);
    rst_ni = 1'b1;
    req    = 4'b0101;
    expect_launch(0, 8'h5A);
    req = 4'b0000;
    complete(0);

    // Inputs changed in the LAUNCH cycle do not affect the latched frame.
    data_in[15:8] = 8'h3C;
    req = 4'b0010;
    expect_launch(1, 8'h3C);
    req           = 4'b0000;
    data_in[15:8] = 8'h00;
    complete(1);
    chk("lk_data_kept", 32'(tx_data), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
